// File: rtl/uart_cmd_parser.sv
// Frame controller behind the UART receiver: finds HDR0/HDR1 frames, verifies CHK and issues write/read strobes.
// Strobes and err_flag are registered, one cycle after the CHK byte; the block never backpressures.
module uart_cmd_parser #(
   parameter int unsigned UART_BPS      = 9600,
   parameter int unsigned CLK_FREQ      = 50_000_000,
   parameter logic [7:0]  HDR0          = 8'h55,
   parameter logic [7:0]  HDR1          = 8'hAA,
   parameter int unsigned TIMEOUT_BYTES = 3
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] pi_data,
   input  logic       pi_flag,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       rd_req,
   output logic [7:0] rd_addr,
   output logic       err_flag,
   output logic [1:0] err_code,
   output logic [7:0] err_cnt
);

   localparam int unsigned TIMEOUT_CYC  = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;
   localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_H1,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_CHK
   } state_t;

   state_t      state;
   logic [7:0]  cmd_q;
   logic [7:0]  addr_q;
   logic [7:0]  data_q;
   logic [7:0]  acc;
   logic [23:0] to_cnt;

   logic        err_hit;
   logic [1:0]  err_code_nxt;
   logic        cmd_wr;
   logic        cmd_rd;

   // A byte arriving on the expiry cycle takes priority over the timeout.
   always_comb begin
      err_hit      = 1'b0;
      err_code_nxt = 2'd0;
      cmd_wr       = 1'b0;
      cmd_rd       = 1'b0;
      if (pi_flag) begin
         if (state == S_CHK) begin
            if (pi_data != acc) begin
               err_hit      = 1'b1;
               err_code_nxt = 2'd1;
            end else if (cmd_q == 8'h01) begin
               cmd_wr = 1'b1;
            end else if (cmd_q == 8'h02) begin
               cmd_rd = 1'b1;
            end else begin
               err_hit      = 1'b1;
               err_code_nxt = 2'd2;
            end
         end
      end else if (state != S_IDLE && to_cnt == TIMEOUT_LAST) begin
         err_hit      = 1'b1;
         err_code_nxt = 2'd3;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= S_IDLE;
         cmd_q    <= 8'd0;
         addr_q   <= 8'd0;
         data_q   <= 8'd0;
         acc      <= 8'd0;
         to_cnt   <= 24'd0;
         wr_en    <= 1'b0;
         wr_addr  <= 8'd0;
         wr_data  <= 8'd0;
         rd_req   <= 1'b0;
         rd_addr  <= 8'd0;
         err_flag <= 1'b0;
         err_code <= 2'd0;
         err_cnt  <= 8'd0;
      end else begin
         wr_en    <= cmd_wr;
         rd_req   <= cmd_rd;
         err_flag <= err_hit;
         if (cmd_wr) begin
            wr_addr <= addr_q;
            wr_data <= data_q;
         end
         if (cmd_rd) begin
            rd_addr <= addr_q;
         end
         if (err_hit) begin
            err_code <= err_code_nxt;
            if (err_cnt != 8'hFF) begin
               err_cnt <= err_cnt + 8'd1;
            end
         end

         if (pi_flag || state == S_IDLE) begin
            to_cnt <= 24'd0;
         end else begin
            to_cnt <= to_cnt + 24'd1;
         end

         if (pi_flag) begin
            case (state)
               S_IDLE: begin
                  if (pi_data == HDR0) state <= S_H1;
               end
               S_H1: begin
                  if (pi_data == HDR1)      state <= S_CMD;
                  else if (pi_data != HDR0) state <= S_IDLE;
               end
               S_CMD: begin
                  cmd_q <= pi_data;
                  acc   <= pi_data;
                  state <= S_ADDR;
               end
               S_ADDR: begin
                  addr_q <= pi_data;
                  acc    <= acc + pi_data;
                  state  <= S_DATA;
               end
               S_DATA: begin
                  data_q <= pi_data;
                  acc    <= acc + pi_data;
                  state  <= S_CHK;
               end
               S_CHK: begin
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end else if (err_hit) begin
            state <= S_IDLE;
         end
      end
   end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Byte-level frame controller placed directly after the UART receiver. Consumes its 8-bit parallel output byte and one-cycle valid flag.
- Finds frames by a two-byte header, checks a checksum, and turns valid frames into single-cycle register write or read-request strobes.
- Enforces an inter-byte timeout and counts framing errors.
- The UART receiver cannot be stalled, so this block never backpressures.

Parameters:
- UART_BPS, 9600: serial baud rate; used only to size the timeout.
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- HDR0, 8'h55: first header byte.
- HDR1, 8'hAA: second header byte.
- TIMEOUT_BYTES, 3: allowed silence between bytes inside a frame, in 10-bit character times.
- Derived constant TIMEOUT_CYC = (CLK_FREQ/UART_BPS)*10*TIMEOUT_BYTES, which is 156240 with the defaults. The timeout counter is 24 bits wide.

Ports:
- sys_clk, in, 1: system clock.
- sys_rst, in, 1: synchronous, active-high reset.
- pi_data, in, 8: received byte; valid only when pi_flag = 1.
- pi_flag, in, 1: one-cycle byte-valid pulse.
- wr_en, out, 1: one-cycle register write strobe.
- wr_addr, out, 8: write address; held until the next write.
- wr_data, out, 8: write data; held until the next write.
- rd_req, out, 1: one-cycle read-request strobe.
- rd_addr, out, 8: read address; held until the next read request.
- err_flag, out, 1: one-cycle frame-error pulse.
- err_code, out, 2: error code. 1 = checksum, 2 = bad command, 3 = timeout. Held until the next error.
- err_cnt, out, 8: saturating error count.

Behaviour:
- Frame format: HDR0, HDR1, CMD, ADDR, DATA, CHK.
  - CHK = (CMD + ADDR + DATA) mod 256.
  - CMD 8'h01 = write; CMD 8'h02 = read request, where the DATA byte is ignored but still included in CHK.
- Reset (sync, sys_rst = 1 at a sys_clk edge):
  - state = IDLE.
  - wr_en, rd_req, err_flag = 0.
  - wr_addr, wr_data, rd_addr = 0; err_code = 0; err_cnt = 0.
  - Checksum accumulator = 0; timeout counter = 0.
  - Reset mid-frame discards the partial frame and produces no error pulse.
- State machine (transitions occur only on pi_flag = 1 unless noted):
  - IDLE: byte == HDR0 goes to H1. Any other byte is ignored.
  - H1: byte == HDR1 goes to CMD. Byte == HDR0 stays in H1 (resync). Any other byte returns to IDLE silently.
  - CMD: latch cmd, set acc = byte, go to ADDR.
  - ADDR: latch addr, acc += byte, go to DATA.
  - DATA: latch data, acc += byte, go to CHK.
  - CHK: evaluate the frame, then return to IDLE:
    - byte != acc: checksum error (code 1).
    - byte == acc and cmd is not 01 or 02: bad-command error (code 2).
    - byte == acc and cmd == 01: wr_en = 1, and wr_addr/wr_data are updated in the same cycle.
    - byte == acc and cmd == 02: rd_req = 1, and rd_addr is updated.
- Latency:
  - The strobe or err_flag is asserted exactly 1 cycle after the pi_flag cycle that carried CHK, and lasts 1 cycle.
  - No output changes on header or body bytes.
- Timeout:
  - The counter clears on every pi_flag and while in IDLE.
  - It increments every cycle in states H1 through CHK.
  - When it equals TIMEOUT_CYC-1 with no pi_flag in that cycle: state goes to IDLE, and one cycle later err_flag = 1 with err_code = 3.
  - If pi_flag coincides with expiry, the byte wins: the counter clears, the byte is processed and no timeout is raised.
- Error counter:
  - err_cnt increments by 1 on each err_flag and saturates at 8'hFF.
  - Silent header mismatches in H1 are not counted.
- Back-to-back frames:
  - A new HDR0 may arrive on the cycle immediately after CHK and is accepted.
  - pi_flag pulses are assumed to be at least 2 cycles apart.
- Output registers:
  - All outputs are registered.
  - wr_en, rd_req and err_flag are mutually exclusive.

Test Plan:
- Write frame 55 AA 01 10 A5 B6 → a single wr_en pulse 1 cycle after the B6 flag, with wr_addr = 8'h10 and wr_data = 8'hA5; err_cnt stays 0.
- Read frame 55 AA 02 20 00 22 → rd_req pulse with rd_addr = 8'h20; wr_en stays 0.
- Bad checksum 55 AA 01 10 A5 00 → err_flag pulse, err_code = 1, err_cnt = 1, no wr_en. A following valid write frame is then accepted normally.
- Bad command 55 AA 07 00 00 07 → err_code = 2. Resync stream 55 55 AA 01 33 44 78 → wr_en with addr 33 and data 44.
- Timeout: send 55 AA 01, then silence → err_flag exactly TIMEOUT_CYC cycles after the 01 flag, err_code = 3. A byte arriving on the expiry cycle causes no error.
- Saturation and reset: inject 256 bad-checksum frames → err_cnt = FF and holds. Assert sys_rst for 1 cycle mid-frame (after 55 AA 01) → all outputs 0; the next valid frame parses correctly.
